hilo_unit: RTL

Holds the architectural HI/LO registers for the multi-cycle MIPS datapath and sits directly downstream of the ALU. It captures the ALU's `res_high`/`res_low` pair on multiply and divide, and waits on the ALU's `divDone` for divides. It also services `mthi`/`mtlo` writes and `mfhi`/`mflo` reads, and gives the control FSM a stall signal while a divide is in flight. A timeout counter guards against a divide that never completes.

---
 rtl/hilo_unit.sv | 85 ++++++++
 1 files changed

// File: rtl/hilo_unit.sv
// hilo_unit: MIPS HI/LO registers with mult/div capture, mthi/mtlo, divide wait with timeout.
// Define HILO_FWD_EN to forward the ALU divide result to rd_data on the divdone cycle.
module hilo_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op_kind,
    input  logic [WIDTH-1:0] alu_hi,
    input  logic [WIDTH-1:0] alu_lo,
    input  logic             alu_divdone,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_valid,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_timeout
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, DIV_WAIT} stateT;
    stateT state, nextState;
    logic [CW-1:0] count;
    logic accept, isDiv, divFin, divAbort, fwdHit, wrHi, wrLo, useAlu;

    assign busy     = state == DIV_WAIT;
    assign accept   = op_valid & ~busy;
    assign isDiv    = op_kind == 2'b01;
    assign divFin   = busy & alu_divdone;
    assign divAbort = busy & ~alu_divdone & (count == CW'(TIMEOUT - 1));
    assign useAlu   = divFin | (op_kind == 2'b00);
    assign wrHi     = divFin | (accept & (op_kind == 2'b00 | op_kind == 2'b10));
    assign wrLo     = divFin | (accept & (op_kind == 2'b00 | op_kind == 2'b11));

`ifdef HILO_FWD_EN
    assign fwdHit  = divFin;
    assign rd_data = fwdHit ? (rd_sel ? alu_hi : alu_lo) : (rd_sel ? hi : lo);
`else
    assign fwdHit  = 1'b0;
    assign rd_data = rd_sel ? hi : lo;
`endif

    assign stall = (op_valid & busy) | (rd_valid & busy & ~fwdHit);

    always_comb begin
        nextState = state;
        if (accept && isDiv)
            nextState = DIV_WAIT;
        else if (divFin || divAbort)
            nextState = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_timeout <= 1'b0;
        end else begin
            state <= nextState;
            done  <= (accept & ~isDiv) | divFin;
            if (accept)
                div_timeout <= 1'b0;
            else if (divAbort)
                div_timeout <= 1'b1;
            // counter saturates at TIMEOUT-1 because the abort leaves DIV_WAIT on that edge
            if (accept && isDiv)
                count <= '0;
            else if (busy && !divFin && !divAbort)
                count <= count + CW'(1);
            if (wrHi)
                hi <= useAlu ? alu_hi : wdata;
            if (wrLo)
                lo <= useAlu ? alu_lo : wdata;
        end
    end
endmodule
